// File: rtl/aes128_inv_key_schedule.sv
// Iterative inverse AES-128 key schedule: loads the round-10 key and walks back to the
// cipher key, emitting one round key per valid/ready transfer (rounds 10 down to 0).
module aes128_inv_key_schedule #(
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] key_last_i,
  output logic             ready_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic [WIDTH-1:0] rk_o,
  output logic [3:0]       rk_round_o,
  output logic             done_o
);

  // Handshake: a round key transfers on any rising edge where rk_valid_o && rk_ready_i;
  // rk_o/rk_round_o stay stable while rk_valid_o && !rk_ready_i.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [8*256-1:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rk_q, rk_d;
  logic [3:0]       round_q, round_d;
  logic             done_q, done_d;

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      p0, p1, p2, p3;
  logic [31:0]      rot_w, sub_w;
  logic [WIDTH-1:0] prev_rk;

  // Undo one forward expansion step: recover words of round r-1 from round r.
  always_comb begin
    w0      = rk_q[127:96];
    w1      = rk_q[95:64];
    w2      = rk_q[63:32];
    w3      = rk_q[31:0];
    p3      = w3 ^ w2;
    p2      = w2 ^ w1;
    p1      = w1 ^ w0;
    rot_w   = {p3[23:0], p3[31:24]};
    sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    p0      = w0 ^ sub_w ^ {rcon(round_q), 24'h000000};
    prev_rk = {p0, p1, p2, p3};
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rk_d    = key_last_i;
          round_d = 4'd10;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready_i) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rk_d    = prev_rk;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign rk_valid_o = (state_q == RUN);
  assign rk_o       = rk_q;
  assign rk_round_o = round_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_aes128_inv_key_schedule.sv
// Bench for aes128_inv_key_schedule: a forward key-expansion model built on a GF(2^8)
// S-box predicts the reversed round-key stream, checked every cycle on the falling edge.
module tb_aes128_inv_key_schedule;

  logic         clk;
  logic         rst_n_i;
  logic         start_i;
  logic [127:0] key_last_i;
  logic         ready_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         done_o;

  aes128_inv_key_schedule #(.WIDTH(128)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .key_last_i (key_last_i),
    .ready_o    (ready_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .rk_o       (rk_o),
    .rk_round_o (rk_round_o),
    .done_o     (done_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // model state
  logic [7:0]   sbox_m [256];
  logic [127:0] exp_keys [11];
  logic [131:0] exp_q [$];
  logic [131:0] popped;
  bit           armed      = 0;
  bit           busy       = 0;
  bit           done_pend  = 0;
  bit           just_reset = 0;
  int           acc_cnt    = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine(multiplicative inverse), inverse taken as a^254
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] a = 8'(v);
      logic [7:0] r = 8'h01;
      logic [7:0] s, x;
      for (int k = 0; k < 254; k++) r = gmul(r, a);
      s = r;
      x = r;
      for (int k = 0; k < 4; k++) begin
        x = {x[6:0], x[7]};
        s ^= x;
      end
      sbox_m[v] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Forward AES-128 key expansion into exp_keys[0..10]
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // scoreboard: compare on falling edge, then advance model with the inputs the DUT will sample
  always @(negedge clk) begin
    if (armed) begin
      check("ready_o", 128'(ready_o), 128'(!busy));
      check("rk_valid_o", 128'(rk_valid_o), 128'(busy));
      check("done_o", 128'(done_o), 128'(done_pend));
      if (busy && exp_q.size() > 0) begin
        check("rk_o", rk_o, exp_q[0][127:0]);
        check("rk_round_o", 128'(rk_round_o), 128'(exp_q[0][131:128]));
      end else if (just_reset) begin
        check("rk_o_reset", rk_o, 128'h0);
        check("rk_round_o_reset", 128'(rk_round_o), 128'h0);
      end
    end
    if (!rst_n_i) begin
      armed      = 1;
      busy       = 0;
      done_pend  = 0;
      just_reset = 1;
      exp_q.delete();
    end else if (armed) begin
      done_pend = 0;
      if (busy && rk_ready_i) begin
        popped = exp_q.pop_front();
        if (popped[131:128] == 4'd0) begin
          busy      = 0;
          done_pend = 1;
        end
      end else if (!busy && start_i) begin
        for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), exp_keys[r]});
        busy       = 1;
        just_reset = 0;
        acc_cnt++;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input logic [127:0] cipher, input int ready_pct, input int rst_round);
    int cnt = 0;
    expand(cipher);
    key_last_i = exp_keys[10];
    start_i    = 1'b1;
    rk_ready_i = ($urandom_range(99) < ready_pct);
    tick();
    start_i = 1'b0;
    while (busy && cnt < 300) begin
      if (rst_round >= 0 && exp_q.size() > 0 && int'(exp_q[0][131:128]) == rst_round) begin
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
      end else begin
        rk_ready_i = ($urandom_range(99) < ready_pct);
        tick();
      end
      cnt++;
    end
    if (cnt >= 300) check("seq_timeout", 128'(cnt), 128'd0);
    rk_ready_i = 1'b0;
    key_last_i = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) tick();
  endtask

  // start held high mid-sequence with another key: ignored until the engine is idle again
  task automatic start_during_run(input logic [127:0] key_a, input logic [127:0] key_b);
    int cnt = 0;
    int base;
    expand(key_a);
    key_last_i = exp_keys[10];
    start_i    = 1'b1;
    rk_ready_i = 1'b1;
    base       = acc_cnt;
    tick();
    start_i = 1'b0;
    while (cnt < 300 && acc_cnt < base + 2) begin
      if (!start_i && exp_q.size() > 0 && exp_q[0][131:128] == 4'd5) begin
        expand(key_b);
        key_last_i = exp_keys[10];
        start_i    = 1'b1;
      end
      rk_ready_i = ($urandom_range(99) < 80);
      tick();
      cnt++;
    end
    start_i = 1'b0;
    while (busy && cnt < 300) begin
      rk_ready_i = ($urandom_range(99) < 80);
      tick();
      cnt++;
    end
    if (cnt >= 300) check("run_start_timeout", 128'(cnt), 128'd0);
    rk_ready_i = 1'b0;
    repeat (2) tick();
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    rst_n_i    = 1'b0;
    start_i    = 1'b0;
    rk_ready_i = 1'b0;
    key_last_i = '0;
    build_sbox();

    // literal anchors for the model
    expand(FIPS_KEY);
    check("model_rk10", exp_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_rk9", exp_keys[9], 128'hac7766f319fadc2128d12941575c006e);
    check("model_rk1", exp_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    expand(128'h0);
    check("model_zero_rk10", exp_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    repeat (3) tick();
    rst_n_i = 1'b1;
    repeat (2) tick();

    run_seq(FIPS_KEY, 100, -1);
    run_seq(FIPS_KEY, 50, -1);
    run_seq(128'h0, 70, -1);
    start_during_run(FIPS_KEY, {$urandom, $urandom, $urandom, $urandom});
    run_seq(FIPS_KEY, 100, 5);
    run_seq(FIPS_KEY, 100, -1);
    for (int k = 0; k < 8; k++)
      run_seq({$urandom, $urandom, $urandom, $urandom}, $urandom_range(30, 100), -1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
